// File: rtl/level_controller_if.sv
// level_controller_if: start/score inputs and game status outputs between
// the level controller (slave) and whoever drives it (master).
interface level_controller_if;
  logic        start;
  logic [7:0]  score;
  logic        game;
  logic [27:0] speed;
  logic [2:0]  level;
  logic [7:0]  time_left;
  logic        game_over;
  logic [7:0]  final_score;
  logic [7:0]  high_score;
  modport master (
    output start, score,
    input  game, speed, level, time_left, game_over, final_score, high_score
  );
  modport slave (
    input  start, score,
    output game, speed, level, time_left, game_over, final_score, high_score
  );
endinterface

// File: rtl/level_controller.sv
// level_controller: game-level FSM that runs a seconds countdown, raises the
// level and shortens mole on-time as score grows, and latches final/high score.
module level_controller #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int GAME_SECONDS = 60,
  parameter int BASE_SPEED   = 50_000_000,
  parameter int SPEED_STEP   = 10_000_000,
  parameter int MIN_SPEED    = 10_000_000,
  parameter int LEVEL_STEP   = 10,
  parameter int MAX_LEVEL    = 3
) (
  input logic clock,
  input logic reset,
  level_controller_if.slave bus
);
  localparam int PW = $clog2(CLK_HZ + 1);
  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
  state_t state, state_d;
  logic start_q, start_rise, enter, tick, terminal, lvl_up;
  logic [PW-1:0] pre, pre_d;
  logic [7:0] tl_d, fs_d, hs_d;
  logic [2:0] lvl_d;
  logic [27:0] spd_d, spd_f;
  logic [10:0] thr;
  logic signed [30:0] diff;
  assign start_rise = bus.start & ~start_q;
  assign enter      = state != PLAY && start_rise;
  assign tick       = state == PLAY && pre == PW'(CLK_HZ - 1);
  assign terminal   = tick && bus.time_left == 8'd1;
  assign thr        = 11'(LEVEL_STEP) * (11'(bus.level) + 11'd1);
  assign lvl_up     = state == PLAY && !terminal && bus.level < 3'(MAX_LEVEL) && {3'b000, bus.score} >= thr;
  assign diff       = $signed(31'(BASE_SPEED)) - $signed(31'(SPEED_STEP)) * $signed({28'd0, bus.level});
  assign spd_f      = diff < $signed(31'(MIN_SPEED)) ? 28'(MIN_SPEED) : diff[27:0];
  always_ff @(posedge clock)
    state <= reset ? IDLE : state_d;
  always_comb
    state_d = state == PLAY ? (terminal ? OVER : PLAY) : (start_rise ? PLAY : state);
  always_comb begin
    pre_d = enter || tick ? '0 : state == PLAY ? pre + 1'b1 : pre;
    tl_d  = enter ? 8'(GAME_SECONDS) : tick ? bus.time_left - 8'd1 : bus.time_left;
    lvl_d = enter ? 3'd0 : lvl_up ? bus.level + 3'd1 : bus.level;
    spd_d = enter ? 28'(BASE_SPEED) : state == PLAY ? spd_f : bus.speed;
    fs_d  = terminal ? bus.score : bus.final_score;
    hs_d  = terminal && bus.score > bus.high_score ? bus.score : bus.high_score;
  end
  // start_q keeps sampling through reset so a button held across reset cannot start a round
  always_ff @(posedge clock) begin
    start_q <= bus.start;
    if (reset) begin
      pre             <= '0;
      bus.game        <= 1'b0;
      bus.game_over   <= 1'b0;
      bus.time_left   <= 8'(GAME_SECONDS);
      bus.level       <= 3'd0;
      bus.speed       <= 28'(BASE_SPEED);
      bus.final_score <= 8'd0;
      bus.high_score  <= 8'd0;
    end else begin
      pre             <= pre_d;
      bus.game        <= state_d == PLAY;
      bus.game_over   <= state_d == OVER;
      bus.time_left   <= tl_d;
      bus.level       <= lvl_d;
      bus.speed       <= spd_d;
      bus.final_score <= fs_d;
      bus.high_score  <= hs_d;
    end
  end
endmodule

// File: tb/tb_level_controller.sv
// tb_level_controller: directed stimulus for level_controller, checked every
// cycle against a rule-level model plus hand-computed literal expectations.
module tb_level_controller;
  localparam int CLK_HZ = 10, GS = 3, LSTEP = 2, BASE = 100, STEP = 30, MINS = 20, MAXL = 3;
  logic clock = 1'b0, reset = 1'b1;
  int vectors = 0, miscompares = 0;
  level_controller_if bus();
  level_controller #(
    .CLK_HZ(CLK_HZ), .GAME_SECONDS(GS), .BASE_SPEED(BASE), .SPEED_STEP(STEP),
    .MIN_SPEED(MINS), .LEVEL_STEP(LSTEP), .MAX_LEVEL(MAXL)
  ) dut (.clock(clock), .reset(reset), .bus(bus.slave));
  always #5 clock = ~clock;
  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Model: rounds as seconds counted in clock cycles, levels as score thresholds.
  bit playing = 0, over = 0, m_sq = 0;
  int cyc_in_sec = 0, m_tl = GS, m_lvl = 0, m_spd = BASE, m_fs = 0, m_hs = 0;
  always @(posedge clock) begin
    bit rise, sec_end, last;
    rise = bus.start && !m_sq;
    if (reset) begin
      playing = 0; over = 0; cyc_in_sec = 0; m_tl = GS; m_lvl = 0; m_spd = BASE; m_fs = 0; m_hs = 0;
    end else if (!playing) begin
      if (rise) begin
        playing = 1; over = 0; cyc_in_sec = 0; m_tl = GS; m_lvl = 0; m_spd = BASE;
      end
    end else begin
      sec_end = cyc_in_sec == CLK_HZ - 1;
      last = sec_end && m_tl == 1;
      m_spd = BASE - m_lvl * STEP < MINS ? MINS : BASE - m_lvl * STEP;
      if (!last && m_lvl < MAXL && int'(bus.score) >= LSTEP * (m_lvl + 1)) m_lvl++;
      cyc_in_sec = sec_end ? 0 : cyc_in_sec + 1;
      if (sec_end) m_tl--;
      if (last) begin
        playing = 0; over = 1; m_fs = bus.score;
        if (m_fs > m_hs) m_hs = m_fs;
      end
    end
    m_sq = bus.start;
  end
  always @(negedge clock) if (!reset) begin
    check("game", bus.game, playing);
    check("game_over", bus.game_over, over);
    check("time_left", bus.time_left, m_tl);
    check("level", bus.level, m_lvl);
    check("speed", bus.speed, m_spd);
    check("final_score", bus.final_score, m_fs);
    check("high_score", bus.high_score, m_hs);
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic begin_round();
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask
  task automatic wait_over();
    int n = 0;
    while (!bus.game_over && n < 100) begin
      cyc(1);
      n++;
    end
    check("over_timeout", bus.game_over, 1);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.score = 8'd0;
    cyc(2);
    reset = 1'b0;
    check("rst_game", bus.game, 0);
    check("rst_speed", bus.speed, 100);
    check("rst_time", bus.time_left, 3);
    check("rst_high", bus.high_score, 0);
    begin_round();
    check("t1_game", bus.game, 1);
    check("t1_tl3", bus.time_left, 3);
    cyc(9);
    check("t1_tl3_end", bus.time_left, 3);
    cyc(1);
    check("t1_tl2", bus.time_left, 2);
    cyc(10);
    check("t1_tl1", bus.time_left, 1);
    cyc(9);
    check("t1_still_play", bus.game, 1);
    cyc(1);
    check("t1_game_end", bus.game, 0);
    check("t1_over", bus.game_over, 1);
    check("t1_tl0", bus.time_left, 0);
    begin_round();
    check("t2_over_clr", bus.game_over, 0);
    cyc(4);
    bus.score = 8'd2;
    cyc(1);
    check("t2_lvl1", bus.level, 1);
    check("t2_spd100", bus.speed, 100);
    cyc(1);
    check("t2_spd70", bus.speed, 70);
    bus.score = 8'd4;
    cyc(1);
    check("t2_lvl2", bus.level, 2);
    cyc(1);
    check("t2_spd40", bus.speed, 40);
    bus.score = 8'd1;
    cyc(5);
    check("t4_lvl_hold", bus.level, 2);
    check("t4_spd_hold", bus.speed, 40);
    bus.start = 1'b1;
    cyc(2);
    bus.start = 1'b0;
    check("t4_start_ignored", bus.game, 1);
    bus.score = 8'd7;
    wait_over();
    check("t5_final7", bus.final_score, 7);
    check("t5_high7", bus.high_score, 7);
    check("t5_lvl3", bus.level, 3);
    bus.score = 8'd0;
    begin_round();
    check("t3_lvl0", bus.level, 0);
    check("t3_spd100", bus.speed, 100);
    bus.score = 8'd9;
    cyc(1);
    check("t3_lvl1", bus.level, 1);
    cyc(1);
    check("t3_lvl2", bus.level, 2);
    check("t3_spd70", bus.speed, 70);
    cyc(1);
    check("t3_lvl3", bus.level, 3);
    check("t3_spd40", bus.speed, 40);
    cyc(2);
    check("t3_lvl_cap", bus.level, 3);
    check("t3_spd_min", bus.speed, 20);
    bus.score = 8'd5;
    wait_over();
    check("t5_final5", bus.final_score, 5);
    check("t5_high_keep", bus.high_score, 7);
    begin_round();
    bus.score = 8'd3;
    cyc(3);
    bus.start = 1'b1;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("t6_game0", bus.game, 0);
    check("t6_high0", bus.high_score, 0);
    cyc(5);
    check("t6_held_start", bus.game, 0);
    bus.start = 1'b0;
    cyc(1);
    begin_round();
    check("t6_restart", bus.game, 1);
    cyc(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
